// File: rtl/trap_ctrl_mh_pkg.sv
// Shared encodings for the multi-hart machine-mode trap sequencer.
package trap_ctrl_mh_pkg;

  // Interrupt cause codes (mcause[XLEN-2:0] when mcause[XLEN-1] is set)
  localparam int unsigned MCAUSE_MEI = 11;
  localparam int unsigned MCAUSE_MSI = 3;
  localparam int unsigned MCAUSE_MTI = 7;
  localparam int unsigned MCAUSE_CODE_W = 4;

  // mstatus fields owned by this block
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  // mie / mip bit positions (match the cause codes)
  localparam int unsigned MIX_MSI_BIT = 3;
  localparam int unsigned MIX_MTI_BIT = 7;
  localparam int unsigned MIX_MEI_BIT = 11;

  // CSR write target selection
  typedef enum logic [1:0] {
    CsrSelMstatus = 2'd0,
    CsrSelMepc    = 2'd1,
    CsrSelMcause  = 2'd2,
    CsrSelMtval   = 2'd3
  } csr_sel_e;

  // Per-hart trap FSM
  typedef enum logic {
    StIdle = 1'b0,
    StPend = 1'b1
  } slot_state_e;

  // Fixed interrupt priority: MEI > MSI > MTI. Caller guarantees one is set.
  function automatic logic [MCAUSE_CODE_W-1:0] irq_code(input logic mei, input logic msi,
                                                        input logic mti);
    logic [MCAUSE_CODE_W-1:0] code;
    code = MCAUSE_CODE_W'(MCAUSE_MTI);
    if (mei) begin
      code = MCAUSE_CODE_W'(MCAUSE_MEI);
    end else if (msi) begin
      code = MCAUSE_CODE_W'(MCAUSE_MSI);
    end else if (mti) begin
      code = MCAUSE_CODE_W'(MCAUSE_MTI);
    end
    return code;
  endfunction

endpackage

// File: rtl/trap_ctrl_mh_hart_slot.sv
// One hart's trap FSM, capture registers and trap CSRs (MIE/MPIE, mepc, mcause, mtval).
module trap_ctrl_mh_hart_slot
  import trap_ctrl_mh_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // Exception reported for this hart
  input  logic            exc_hit,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  // Already masked with the per-hart enables
  input  logic            irq_mei,
  input  logic            irq_msi,
  input  logic            irq_mti,
  input  logic [XLEN-1:0] hart_pc,
  input  logic            mret_hit,
  input  logic            csr_hit,
  input  logic [1:0]      csr_sel,
  input  logic [XLEN-1:0] csr_wdata,
  // Arbiter handshake granted to this hart
  input  logic            commit,
  output logic            hold,
  output logic [XLEN-1:0] pend_cause,
  output logic            mie,
  output logic            mpie,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval
);

  slot_state_e     state_q;
  logic [XLEN-1:0] cap_cause_q;
  logic [XLEN-1:0] cap_epc_q;
  logic [XLEN-1:0] cap_tval_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic            mie_q;
  logic            mpie_q;

  logic            irq_any;
  logic [XLEN-1:0] irq_cause;
  logic            take_exc;
  logic            take_irq;
  logic            do_commit;
  logic            do_mret;
  logic            do_csr;
  csr_sel_e        sel;

  // Decide which event acts on this hart this cycle (commit > mret > csr write)
  always_comb begin
    sel       = csr_sel_e'(csr_sel);
    irq_any   = irq_mei | irq_msi | irq_mti;
    irq_cause = {1'b1, (XLEN-1)'(irq_code(irq_mei, irq_msi, irq_mti))};
    take_exc  = (state_q == StIdle) && exc_hit;
    take_irq  = (state_q == StIdle) && !exc_hit && mie_q && irq_any;
    do_commit = (state_q == StPend) && commit;
    // A trap captured in the same cycle wins over MRET; MRET in PEND is dropped
    do_mret   = (state_q == StIdle) && mret_hit && !take_exc && !take_irq;
    do_csr    = csr_hit && !do_commit && !do_mret;
  end

  // FSM, capture and CSR state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cap_cause_q <= '0;
      cap_epc_q   <= '0;
      cap_tval_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mie_q       <= 1'b0;
      mpie_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take_exc) begin
            state_q     <= StPend;
            cap_cause_q <= exc_cause;
            cap_epc_q   <= exc_pc;
            cap_tval_q  <= exc_tval;
          end else if (take_irq) begin
            state_q     <= StPend;
            cap_cause_q <= irq_cause;
            cap_epc_q   <= hart_pc;
            cap_tval_q  <= '0;
          end
        end
        StPend: begin
          // Capture is frozen here; new exceptions and interrupt levels are ignored
          if (commit) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (do_commit) begin
        mepc_q   <= cap_epc_q;
        mcause_q <= cap_cause_q;
        mtval_q  <= cap_tval_q;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (do_mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (do_csr) begin
        unique case (sel)
          CsrSelMstatus: begin
            mie_q  <= csr_wdata[MSTATUS_MIE_BIT];
            mpie_q <= csr_wdata[MSTATUS_MPIE_BIT];
          end
          CsrSelMepc:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
          CsrSelMcause: mcause_q <= csr_wdata;
          CsrSelMtval:  mtval_q  <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  assign hold       = (state_q == StPend);
  assign pend_cause = cap_cause_q;
  assign mie        = mie_q;
  assign mpie       = mpie_q;
  assign mepc       = mepc_q;
  assign mcause     = mcause_q;
  assign mtval      = mtval_q;

endmodule

// File: rtl/trap_ctrl_mh.sv
// Multi-hart machine-mode trap sequencer: per-hart trap slots plus a round-robin
// arbiter that hands one redirect at a time to fetch over a valid/ready handshake.
module trap_ctrl_mh
  import trap_ctrl_mh_pkg::*;
#(
  parameter int unsigned NUM_HARTS   = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HART_ID_W   = 2,
  parameter int unsigned VECTORED_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [XLEN-1:0]           mtvec,
  input  logic [NUM_HARTS-1:0]      mie_meie,
  input  logic [NUM_HARTS-1:0]      mie_mtie,
  input  logic [NUM_HARTS-1:0]      mie_msie,
  input  logic [NUM_HARTS-1:0]      irq_meip,
  input  logic [NUM_HARTS-1:0]      irq_mtip,
  input  logic [NUM_HARTS-1:0]      irq_msip,
  input  logic [NUM_HARTS*XLEN-1:0] hart_pc,
  input  logic                      exc_valid,
  input  logic [HART_ID_W-1:0]      exc_hart_id,
  input  logic [XLEN-1:0]           exc_cause,
  input  logic [XLEN-1:0]           exc_pc,
  input  logic [XLEN-1:0]           exc_tval,
  input  logic                      mret_valid,
  input  logic [HART_ID_W-1:0]      mret_hart_id,
  input  logic                      csr_we,
  input  logic [HART_ID_W-1:0]      csr_hart_id,
  input  logic [1:0]                csr_sel,
  input  logic [XLEN-1:0]           csr_wdata,
  output logic                      trap_valid,
  input  logic                      trap_ready,
  output logic [HART_ID_W-1:0]      trap_hart_id,
  output logic [XLEN-1:0]           trap_vector,
  output logic [NUM_HARTS-1:0]      hart_hold,
  output logic [NUM_HARTS-1:0]      mstatus_mie,
  output logic [NUM_HARTS-1:0]      mstatus_mpie,
  output logic [NUM_HARTS*XLEN-1:0] mepc_o,
  output logic [NUM_HARTS*XLEN-1:0] mcause_o,
  output logic [NUM_HARTS*XLEN-1:0] mtval_o
);

  logic [NUM_HARTS-1:0] hold;
  logic [NUM_HARTS-1:0] commit_hit;
  logic [XLEN-1:0]      slot_cause [NUM_HARTS];

  logic [HART_ID_W-1:0] ptr_q;
  logic                 lock_q;
  logic [HART_ID_W-1:0] lock_id_q;
  logic [HART_ID_W-1:0] rr_id;
  logic [HART_ID_W-1:0] idx;
  logic                 rr_found;
  logic [HART_ID_W-1:0] grant_id;
  logic                 handshake;
  logic [XLEN-1:0]      grant_cause;
  logic [XLEN-1:0]      vec_base;
  logic                 vec_mode;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_slot
    assign commit_hit[h] = handshake && (grant_id == HART_ID_W'(h));

    trap_ctrl_mh_hart_slot #(
      .XLEN (XLEN)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .exc_hit    (exc_valid && (exc_hart_id == HART_ID_W'(h))),
      .exc_cause  (exc_cause),
      .exc_pc     (exc_pc),
      .exc_tval   (exc_tval),
      .irq_mei    (irq_meip[h] & mie_meie[h]),
      .irq_msi    (irq_msip[h] & mie_msie[h]),
      .irq_mti    (irq_mtip[h] & mie_mtie[h]),
      .hart_pc    (hart_pc[h*XLEN +: XLEN]),
      .mret_hit   (mret_valid && (mret_hart_id == HART_ID_W'(h))),
      .csr_hit    (csr_we && (csr_hart_id == HART_ID_W'(h))),
      .csr_sel    (csr_sel),
      .csr_wdata  (csr_wdata),
      .commit     (commit_hit[h]),
      .hold       (hold[h]),
      .pend_cause (slot_cause[h]),
      .mie        (mstatus_mie[h]),
      .mpie       (mstatus_mpie[h]),
      .mepc       (mepc_o[h*XLEN +: XLEN]),
      .mcause     (mcause_o[h*XLEN +: XLEN]),
      .mtval      (mtval_o[h*XLEN +: XLEN])
    );
  end

  assign hart_hold = hold;

  // Round-robin search over pending harts starting at the pointer
  always_comb begin
    rr_found = 1'b0;
    rr_id    = ptr_q;
    idx      = ptr_q;
    for (int unsigned i = 0; i < NUM_HARTS; i++) begin
      idx = ptr_q + HART_ID_W'(i);
      if (!rr_found && hold[idx]) begin
        rr_found = 1'b1;
        rr_id    = idx;
      end
    end
  end

  // Redirect outputs; a stalled grant is locked so a newly pending hart cannot
  // steal the slot while fetch is not ready
  always_comb begin
    grant_id    = lock_q ? lock_id_q : rr_id;
    trap_valid  = |hold;
    trap_hart_id = grant_id;
    handshake   = trap_valid && trap_ready;
    grant_cause = slot_cause[grant_id];
    vec_base    = {mtvec[XLEN-1:2], 2'b00};
    vec_mode    = (VECTORED_EN != 0) && (mtvec[1:0] == 2'b01);
    trap_vector = vec_base;
    if (vec_mode && grant_cause[XLEN-1]) begin
      trap_vector = vec_base + {grant_cause[XLEN-3:0], 2'b00};
    end
  end

  // Pointer advance on handshake and grant lock while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (handshake) begin
      ptr_q  <= grant_id + HART_ID_W'(1);
      lock_q <= 1'b0;
    end else if (trap_valid) begin
      lock_q    <= 1'b1;
      lock_id_q <= grant_id;
    end
  end

endmodule

// File: tb/tb_trap_ctrl_mh.sv
// Directed bench for trap_ctrl_mh with an expected-redirect scoreboard.
module tb_trap_ctrl_mh;

  localparam int unsigned NH = 4;
  localparam int unsigned XL = 32;
  localparam int unsigned HW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [XL-1:0]  mtvec;
  logic [NH-1:0]  mie_meie, mie_mtie, mie_msie;
  logic [NH-1:0]  irq_meip, irq_mtip, irq_msip;
  logic [NH*XL-1:0] hart_pc;
  logic           exc_valid;
  logic [HW-1:0]  exc_hart_id;
  logic [XL-1:0]  exc_cause, exc_pc, exc_tval;
  logic           mret_valid;
  logic [HW-1:0]  mret_hart_id;
  logic           csr_we;
  logic [HW-1:0]  csr_hart_id;
  logic [1:0]     csr_sel;
  logic [XL-1:0]  csr_wdata;
  logic           trap_ready;

  logic           trap_valid, nv_trap_valid;
  logic [HW-1:0]  trap_hart_id, nv_trap_hart_id;
  logic [XL-1:0]  trap_vector, nv_trap_vector;
  logic [NH-1:0]  hart_hold, nv_hart_hold;
  logic [NH-1:0]  mstatus_mie, mstatus_mpie, nv_mstatus_mie, nv_mstatus_mpie;
  logic [NH*XL-1:0] mepc_o, mcause_o, mtval_o, nv_mepc_o, nv_mcause_o, nv_mtval_o;

  always #5 clk = ~clk;

  trap_ctrl_mh #(
    .NUM_HARTS (NH), .XLEN (XL), .HART_ID_W (HW), .VECTORED_EN (1)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .mtvec (mtvec),
    .mie_meie (mie_meie), .mie_mtie (mie_mtie), .mie_msie (mie_msie),
    .irq_meip (irq_meip), .irq_mtip (irq_mtip), .irq_msip (irq_msip),
    .hart_pc (hart_pc), .exc_valid (exc_valid), .exc_hart_id (exc_hart_id),
    .exc_cause (exc_cause), .exc_pc (exc_pc), .exc_tval (exc_tval),
    .mret_valid (mret_valid), .mret_hart_id (mret_hart_id),
    .csr_we (csr_we), .csr_hart_id (csr_hart_id), .csr_sel (csr_sel), .csr_wdata (csr_wdata),
    .trap_valid (trap_valid), .trap_ready (trap_ready), .trap_hart_id (trap_hart_id),
    .trap_vector (trap_vector), .hart_hold (hart_hold),
    .mstatus_mie (mstatus_mie), .mstatus_mpie (mstatus_mpie),
    .mepc_o (mepc_o), .mcause_o (mcause_o), .mtval_o (mtval_o)
  );

  trap_ctrl_mh #(
    .NUM_HARTS (NH), .XLEN (XL), .HART_ID_W (HW), .VECTORED_EN (0)
  ) u_dut_nv (
    .clk (clk), .rst_n (rst_n), .mtvec (mtvec),
    .mie_meie (mie_meie), .mie_mtie (mie_mtie), .mie_msie (mie_msie),
    .irq_meip (irq_meip), .irq_mtip (irq_mtip), .irq_msip (irq_msip),
    .hart_pc (hart_pc), .exc_valid (exc_valid), .exc_hart_id (exc_hart_id),
    .exc_cause (exc_cause), .exc_pc (exc_pc), .exc_tval (exc_tval),
    .mret_valid (mret_valid), .mret_hart_id (mret_hart_id),
    .csr_we (csr_we), .csr_hart_id (csr_hart_id), .csr_sel (csr_sel), .csr_wdata (csr_wdata),
    .trap_valid (nv_trap_valid), .trap_ready (trap_ready), .trap_hart_id (nv_trap_hart_id),
    .trap_vector (nv_trap_vector), .hart_hold (nv_hart_hold),
    .mstatus_mie (nv_mstatus_mie), .mstatus_mpie (nv_mstatus_mpie),
    .mepc_o (nv_mepc_o), .mcause_o (nv_mcause_o), .mtval_o (nv_mtval_o)
  );

  typedef struct packed {
    logic [HW-1:0] hart;
    logic [XL-1:0] vec;
    logic [XL-1:0] nv_vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XL-1:0] sl(input logic [NH*XL-1:0] v, input int h);
    return v[h*XL +: XL];
  endfunction

  task automatic push_exp(input logic [HW-1:0] h, input logic [XL-1:0] v,
                          input logic [XL-1:0] nv);
    exp_t e;
    e.hart   = h;
    e.vec    = v;
    e.nv_vec = nv;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for a handshake window, then compare against the scoreboard head
  task automatic expect_grant(input string tag);
    exp_t e;
    int   cnt;
    cnt = 0;
    while (!(trap_valid && trap_ready) && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_handshake"}, 32'(trap_valid && trap_ready), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_hart_id"}, 32'(trap_hart_id), 32'(e.hart));
      chk({tag, "_vector"}, trap_vector, e.vec);
      chk({tag, "_nv_vector"}, nv_trap_vector, e.nv_vec);
    end
  endtask

  task automatic csr_wr(input logic [HW-1:0] h, input logic [1:0] sel, input logic [XL-1:0] d);
    csr_we      = 1'b1;
    csr_hart_id = h;
    csr_sel     = sel;
    csr_wdata   = d;
    tick();
    csr_we      = 1'b0;
  endtask

  task automatic raise_exc(input logic [HW-1:0] h, input logic [XL-1:0] cause,
                           input logic [XL-1:0] pc, input logic [XL-1:0] tval);
    exc_valid   = 1'b1;
    exc_hart_id = h;
    exc_cause   = cause;
    exc_pc      = pc;
    exc_tval    = tval;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;  mtvec = 32'h1001;
    mie_meie = '0; mie_mtie = '0; mie_msie = '0;
    irq_meip = '0; irq_mtip = '0; irq_msip = '0;
    hart_pc = '0;
    exc_valid = 1'b0; exc_hart_id = '0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret_valid = 1'b0; mret_hart_id = '0;
    csr_we = 1'b0; csr_hart_id = '0; csr_sel = '0; csr_wdata = '0;
    trap_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(trap_valid), 32'd0);
    chk("rst_hold", 32'(hart_hold), 32'd0);
    chk("rst_mie", 32'(mstatus_mie), 32'd0);
    chk("rst_mepc1", sl(mepc_o, 1), 32'd0);
    rst_n = 1'b1;
    tick();

    // Exception on hart1, fetch always ready
    trap_ready = 1'b1;
    raise_exc(2'd1, 32'd2, 32'h100, 32'hDEAD);
    push_exp(2'd1, 32'h1000, 32'h1000);
    tick();
    exc_valid = 1'b0;
    chk("t1_valid", 32'(trap_valid), 32'd1);
    chk("t1_hold", 32'(hart_hold), 32'b0010);
    expect_grant("t1");
    tick();
    chk("t1_mepc", sl(mepc_o, 1), 32'h100);
    chk("t1_mcause", sl(mcause_o, 1), 32'd2);
    chk("t1_mtval", sl(mtval_o, 1), 32'hDEAD);
    chk("t1_mie", 32'(mstatus_mie[1]), 32'd0);
    chk("t1_hold_clr", 32'(hart_hold), 32'd0);

    // MEI beats MTI on hart0, vectored vs direct
    csr_wr(2'd0, 2'd0, 32'h8);
    chk("t2_mie_set", 32'(mstatus_mie[0]), 32'd1);
    mie_meie[0] = 1'b1; mie_mtie[0] = 1'b1;
    irq_meip[0] = 1'b1; irq_mtip[0] = 1'b1;
    hart_pc[31:0] = 32'h400;
    push_exp(2'd0, 32'h102C, 32'h1000);
    tick();
    expect_grant("t2");
    tick();
    irq_meip = '0; irq_mtip = '0; mie_meie = '0; mie_mtie = '0;
    chk("t2_mcause", sl(mcause_o, 0), 32'h8000000B);
    chk("t2_mepc", sl(mepc_o, 0), 32'h400);
    chk("t2_mtval", sl(mtval_o, 0), 32'd0);
    chk("t2_mie", 32'(mstatus_mie[0]), 32'd0);
    chk("t2_mpie", 32'(mstatus_mpie[0]), 32'd1);

    // Round robin from pointer 0 with harts 0, 2, 3 pending together
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    csr_wr(2'd0, 2'd0, 32'h8);
    csr_wr(2'd2, 2'd0, 32'h8);
    csr_wr(2'd3, 2'd0, 32'h8);
    trap_ready = 1'b0;
    mie_msie = 4'b1101;
    irq_msip = 4'b1101;
    push_exp(2'd0, 32'h100C, 32'h1000);
    push_exp(2'd2, 32'h100C, 32'h1000);
    push_exp(2'd3, 32'h100C, 32'h1000);
    tick();
    chk("t3_hold", 32'(hart_hold), 32'b1101);
    trap_ready = 1'b1;
    expect_grant("rr0");
    tick();
    trap_ready = 1'b0;
    chk("rr_stall_id_a", 32'(trap_hart_id), 32'd2);
    tick();
    chk("rr_stall_valid", 32'(trap_valid), 32'd1);
    chk("rr_stall_id_b", 32'(trap_hart_id), 32'd2);
    chk("rr_stall_vec", trap_vector, 32'h100C);
    trap_ready = 1'b1;
    expect_grant("rr1");
    tick();
    expect_grant("rr2");
    tick();
    irq_msip = '0; mie_msie = '0;
    chk("t3_hold_clr", 32'(hart_hold), 32'd0);

    // Exception and MRET on hart2 together: capture wins
    csr_wr(2'd2, 2'd0, 32'h8);
    trap_ready = 1'b0;
    raise_exc(2'd2, 32'd5, 32'h300, 32'h55);
    mret_valid = 1'b1; mret_hart_id = 2'd2;
    push_exp(2'd2, 32'h1000, 32'h1000);
    tick();
    exc_valid = 1'b0; mret_valid = 1'b0;
    chk("t4_mie_kept", 32'(mstatus_mie[2]), 32'd1);
    chk("t4_mpie_kept", 32'(mstatus_mpie[2]), 32'd0);
    chk("t4_hold", 32'(hart_hold[2]), 32'd1);
    trap_ready = 1'b1;
    expect_grant("t4");
    tick();
    chk("t4_mie_commit", 32'(mstatus_mie[2]), 32'd0);
    chk("t4_mpie_commit", 32'(mstatus_mpie[2]), 32'd1);
    chk("t4_mcause", sl(mcause_o, 2), 32'd5);
    mret_valid = 1'b1; mret_hart_id = 2'd2;
    tick();
    mret_valid = 1'b0;
    chk("t4_mret_mie", 32'(mstatus_mie[2]), 32'd1);
    chk("t4_mret_mpie", 32'(mstatus_mpie[2]), 32'd1);

    // mepc alignment, then a CSR write colliding with hart3's commit
    csr_wr(2'd3, 2'd1, 32'h203);
    chk("t5_mepc_align", sl(mepc_o, 3), 32'h200);
    trap_ready = 1'b0;
    raise_exc(2'd3, 32'd4, 32'h340, 32'h77);
    push_exp(2'd3, 32'h1000, 32'h1000);
    tick();
    exc_valid = 1'b0;
    trap_ready = 1'b1;
    csr_we = 1'b1; csr_hart_id = 2'd3; csr_sel = 2'd1; csr_wdata = 32'h999;
    expect_grant("t5");
    tick();
    csr_we = 1'b0;
    chk("t5_mepc_commit", sl(mepc_o, 3), 32'h340);
    chk("t5_mcause", sl(mcause_o, 3), 32'd4);
    chk("t5_mtval", sl(mtval_o, 3), 32'h77);

    // Reset while hart1 is pending and fetch is stalled
    trap_ready = 1'b0;
    raise_exc(2'd1, 32'd1, 32'h500, 32'h1);
    tick();
    exc_valid = 1'b0;
    chk("t6_hold_pre", 32'(hart_hold), 32'b0010);
    chk("t6_valid_pre", 32'(trap_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_valid", 32'(trap_valid), 32'd0);
    chk("t6_nv_valid", 32'(nv_trap_valid), 32'd0);
    chk("t6_hold", 32'(hart_hold), 32'd0);
    chk("t6_mie", 32'(mstatus_mie), 32'd0);
    chk("t6_mpie", 32'(mstatus_mpie), 32'd0);
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("t6_mepc%0d", h), sl(mepc_o, h), 32'd0);
      chk($sformatf("t6_mcause%0d", h), sl(mcause_o, h), 32'd0);
      chk($sformatf("t6_mtval%0d", h), sl(mtval_o, h), 32'd0);
    end
    tick();
    chk("t6_valid_after", 32'(trap_valid), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl_mh.md
Name: trap_ctrl_mh

Overview:
- Multi-hart, multi-source machine-mode trap sequencer for the barrel core. Successor to the single-hart, external-interrupt-only combinational trap decision.
- Handles synchronous exceptions plus MEI/MSI/MTI per hart, owns per-hart mstatus.MIE/MPIE, mepc, mcause and mtval.
- Arbitrates round-robin between harts and hands the chosen redirect to fetch with a valid/ready handshake.
- Sits between the execute/commit stage, the interrupt sources (PLIC/CLINT) and the CSR file. The CSR file reads the trap state here and forwards its writes here.

Parameters:
- NUM_HARTS, 4, number of hardware threads (power of two, ≥2)
- XLEN, 32, data/address width
- HART_ID_W, 2, hart id width; must equal log2(NUM_HARTS)
- VECTORED_EN, 1, 1 enables mtvec vectored mode for interrupts

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- mtvec  in  XLEN  shared trap vector; [1:0]=01 selects vectored mode
- mie_meie / mie_mtie / mie_msie  in  NUM_HARTS  per-hart enable bits
- irq_meip / irq_mtip / irq_msip  in  NUM_HARTS  level interrupt pending
- hart_pc  in  NUM_HARTS*XLEN  per-hart next-to-execute PC (interrupt mepc)
- exc_valid  in  1  exception reported this cycle
- exc_hart_id  in  HART_ID_W  hart raising the exception
- exc_cause  in  XLEN  exception code (bit XLEN-1 = 0)
- exc_pc  in  XLEN  faulting PC
- exc_tval  in  XLEN  trap value
- mret_valid  in  1  MRET retired
- mret_hart_id  in  HART_ID_W  hart retiring the MRET
- csr_we  in  1  CSR write strobe
- csr_hart_id  in  HART_ID_W  target hart of the CSR write
- csr_sel  in  2  0=mstatus, 1=mepc, 2=mcause, 3=mtval
- csr_wdata  in  XLEN  CSR write data
- trap_valid  out  1  redirect request to fetch
- trap_ready  in  1  fetch accepts the redirect
- trap_hart_id  out  HART_ID_W  hart being redirected
- trap_vector  out  XLEN  redirect target
- hart_hold  out  NUM_HARTS  hart has a trap pending; stall issue
- mstatus_mie / mstatus_mpie  out  NUM_HARTS  per-hart status bits
- mepc_o / mcause_o / mtval_o  out  NUM_HARTS*XLEN  per-hart trap CSRs

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All FSMs go to IDLE.
  - MIE, MPIE, mepc, mcause, mtval are cleared to 0.
  - trap_valid=0, hart_hold=0, round-robin pointer=0.
  - Any pending capture is discarded.
- Per-hart FSM:
  - IDLE -> PEND when exc_valid with exc_hart_id==h.
    - Captures cause=exc_cause, epc=exc_pc, tval=exc_tval.
  - Otherwise IDLE -> PEND when MIE[h] and any enabled pending interrupt.
    - Priority is MEI(11) > MSI(3) > MTI(7).
    - Captures cause={1,code}, epc=hart_pc[h], tval=0.
  - Exceptions beat interrupts in the same cycle.
  - PEND -> IDLE on the handshake (trap_valid & trap_ready & trap_hart_id==h).
  - Commit on the handshake edge: mepc/mcause/mtval <= captured, MPIE <= MIE, MIE <= 0.
- PEND holds the capture stable:
  - Further exc_valid for that hart is ignored (its pipeline is flushed).
  - Interrupt lines are not resampled.
- hart_hold[h] = (state==PEND). It is registered and asserts the cycle after the capture edge.
- Arbiter:
  - Among PEND harts, round-robin starting at the pointer.
  - trap_valid, trap_hart_id and trap_vector are stable while valid & !ready.
  - On the handshake, pointer <= granted+1 (wraps modulo NUM_HARTS).
  - Minimum latency: event at edge N, trap_valid high in N+1, commit at the first edge with ready.
- trap_vector:
  - Default is {mtvec[XLEN-1:2],2'b00}.
  - If VECTORED_EN, mtvec[1:0]==01 and the cause is an interrupt: base + 4*code.
- MRET for hart h in IDLE: MIE <= MPIE, MPIE <= 1. MRET for a hart in PEND is ignored.
- CSR writes:
  - mstatus updates only MIE(bit 3) and MPIE(bit 7).
  - mepc write clears bits [1:0].
  - mcause and mtval take the full word.
- Same-cycle collisions, same hart:
  - trap commit > mret > csr write; the losers are dropped.
  - Exception capture and MRET together: capture wins, MRET ignored.
- Different harts proceed independently in the same cycle.
- Interrupt inputs are level; the source clears them. No edge detection is done.

Decomposition:
- Add to defines.vh:
  - cause codes (MCAUSE_MEI/MSI/MTI, interrupt bit)
  - MSTATUS_MIE_BIT / MPIE_BIT
  - MIE/MIP bit indices
  - CSR_SEL_* encodings
  - FSM state encodings
- One sub-module trap_hart_slot holds the per-hart FSM, capture registers and CSR state. It is instantiated NUM_HARTS times by generate.
- The round-robin arbiter and vector mux stay in the top.

Test Plan:
- Reset, then exc_valid hart1 cause=2 pc=0x100 tval=0xDEAD with trap_ready=1:
  - trap_valid next cycle, trap_hart_id=1, vector=mtvec&~3.
  - After commit: mepc_o[1]=0x100, mcause=2, mtval=0xDEAD, MIE[1]=0.
- Hart0 MIE=1, meie=mtie=1, irq_meip and irq_mtip high, mtvec=0x1001:
  - mcause=0x8000000B, vector=0x102C.
  - With VECTORED_EN=0: vector=0x1000.
- Harts 0, 2 and 3 all PEND, trap_ready toggling 1-0-1:
  - Grants in order 0, 2, 3.
  - Outputs stable across the ready=0 cycle.
- Exception and MRET on hart2 in the same cycle:
  - Capture wins, MIE unchanged by MRET.
  - A later MRET in IDLE restores MIE from MPIE and sets MPIE=1.
- CSR write mepc=0x203 on hart3 → mepc_o[3]=0x200.
  - A CSR write on the same cycle as hart3's commit is lost, and the commit value is held.
- rst_n=0 while hart1 is PEND with trap_ready=0:
  - Next cycle: trap_valid=0, hart_hold=0, all CSRs 0.
